pulse_pattern_decoder: RTL and testbench



---
 rtl/pulse_pattern_decoder.sv | 149 ++++++++++++++
 tb/tb_pulse_pattern_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pulse_pattern_decoder.sv
// Beeper pulse-line receiver: measures mark/space widths in ms, collects dots/dashes into frames.
// Optional SOS comparator is built only when PULSE_DEC_SOS_EN is defined.
module pulse_pattern_decoder #(
  parameter logic [15:0] T1MS         = 16'd49_999,
  parameter logic [9:0]  MIN_PULSE_MS = 10'd20,
  parameter logic [9:0]  SHORT_MAX_MS = 10'd200,
  parameter logic [9:0]  LONG_MAX_MS  = 10'd500,
  parameter logic [9:0]  GAP_END_MS   = 10'd150
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Pin_In,
  output logic        Sym_Valid,
  output logic [15:0] Sym_Bits,
  output logic [4:0]  Sym_Len,
  output logic        Sym_Err,
  output logic        SOS_Det,
  output logic        Busy
);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StDone} state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sprev_q;
  logic [15:0] presc_q, presc_d;
  logic [9:0]  ms_q, ms_d;
  logic [15:0] bits_q, bits_d;
  logic [4:0]  len_q, len_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic [15:0] obits_q, obits_d;
  logic [4:0]  olen_q, olen_d;
  logic        oerr_q, oerr_d;
  logic        sos_q, sos_d;
  logic        rise, fall, sos_hit;

  assign rise = sync2_q & ~sprev_q;
  assign fall = ~sync2_q & sprev_q;

`ifdef PULSE_DEC_SOS_EN
  assign sos_hit = (len_q == 5'd9) && (bits_q[8:0] == 9'b000111000) && !err_q;
`else
  assign sos_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    len_d   = len_q;
    err_d   = err_q;
    valid_d = 1'b0;
    sos_d   = 1'b0;
    obits_d = obits_q;
    olen_d  = olen_q;
    oerr_d  = oerr_q;
    unique case (state_q)
      StIdle: begin
        bits_d = '0;
        len_d  = '0;
        err_d  = 1'b0;
        if (rise) state_d = StMark;
      end
      StMark: begin
        if (fall) begin
          state_d = StSpace;
          if (ms_q < MIN_PULSE_MS) begin
            if (len_q == 5'd0) state_d = StIdle;
          end else if (ms_q > LONG_MAX_MS) begin
            err_d = 1'b1;
          end else if (len_q < 5'd16) begin
            bits_d[len_q[3:0]] = (ms_q > SHORT_MAX_MS);
            len_d              = len_q + 5'd1;
          end else begin
            // 17th valid mark: no room left in the frame
            err_d = 1'b1;
          end
        end
      end
      StSpace: begin
        if (rise) state_d = StMark;
        else if (ms_q >= GAP_END_MS) state_d = StDone;
      end
      StDone: begin
        valid_d = 1'b1;
        obits_d = bits_q;
        olen_d  = len_q;
        oerr_d  = err_q;
        sos_d   = sos_hit;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Width timers restart on every state change so each measurement starts at the edge.
  always_comb begin
    presc_d = presc_q + 16'd1;
    ms_d    = ms_q;
    if (state_d != state_q) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (presc_q == T1MS) begin
      presc_d = '0;
      if (ms_q != 10'd1023) ms_d = ms_q + 10'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sprev_q <= 1'b0;
      presc_q <= '0;
      ms_q    <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      obits_q <= '0;
      olen_q  <= '0;
      oerr_q  <= 1'b0;
      sos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= Pin_In;
      sync2_q <= sync1_q;
      sprev_q <= sync2_q;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      obits_q <= obits_d;
      olen_q  <= olen_d;
      oerr_q  <= oerr_d;
      sos_q   <= sos_d;
    end
  end

  assign Sym_Valid = valid_q;
  assign Sym_Bits  = obits_q;
  assign Sym_Len   = olen_q;
  assign Sym_Err   = oerr_q;
  assign SOS_Det   = sos_q;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_pattern_decoder.sv
// Directed bench for pulse_pattern_decoder at 10 cycles/ms: frame table plus reset-abort sequence.
module tb_pulse_pattern_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Pin_In = 1'b0;
  logic        Sym_Valid, Sym_Err, SOS_Det, Busy;
  logic [15:0] Sym_Bits;
  logic [4:0]  Sym_Len;

  pulse_pattern_decoder #(.T1MS(16'd9)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Pin_In   (Pin_In),
    .Sym_Valid(Sym_Valid),
    .Sym_Bits (Sym_Bits),
    .Sym_Len  (Sym_Len),
    .Sym_Err  (Sym_Err),
    .SOS_Det  (SOS_Det),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

`ifdef PULSE_DEC_SOS_EN
  localparam logic SosExp = 1'b1;
`else
  localparam logic SosExp = 1'b0;
`endif

  typedef struct {
    int          n;
    int          dot_ms;
    int          dash_ms;
    int          gap_ms;
    logic [31:0] dash_mask;
    int          glitch_idx;
    int          exp_nvalid;
    logic [4:0]  exp_len;
    logic [15:0] exp_bits;
    logic        exp_err;
    logic        exp_sos;
    logic        chk_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int nsos = 0;
  int fall_cyc = 0;
  int cap_cyc = 0;
  logic [15:0] cap_bits;
  logic [4:0]  cap_len;
  logic        cap_err, cap_sos;

  // Capture strobes just after each active edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (SOS_Det) nsos++;
    if (Sym_Valid) begin
      nvalid++;
      cap_cyc  = cyc;
      cap_bits = Sym_Bits;
      cap_len  = Sym_Len;
      cap_err  = Sym_Err;
      cap_sos  = SOS_Det;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ms(input int ms);
    repeat (ms * 10) @(negedge CLK);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int w;
    int lat;
    nvalid = 0;
    nsos   = 0;
    for (int i = 0; i < v.n; i++) begin
      if (i == v.glitch_idx) w = 10;
      else if (v.dash_mask[i]) w = v.dash_ms;
      else w = v.dot_ms;
      Pin_In = 1'b1;
      wait_ms(w);
      Pin_In   = 1'b0;
      fall_cyc = cyc;
      if (i < v.n - 1) wait_ms(v.gap_ms);
    end
    for (int t = 0; t < 3000 && nvalid == 0; t++) @(negedge CLK);
    wait_ms(2);
    chk($sformatf("v%0d nvalid", idx), nvalid, v.exp_nvalid);
    chk($sformatf("v%0d sos_count", idx), nsos, (v.exp_nvalid != 0) ? 32'(v.exp_sos) : 32'd0);
    if (v.exp_nvalid != 0) begin
      chk($sformatf("v%0d len", idx), cap_len, v.exp_len);
      chk($sformatf("v%0d bits", idx), cap_bits, v.exp_bits);
      chk($sformatf("v%0d err", idx), cap_err, v.exp_err);
      chk($sformatf("v%0d sos", idx), cap_sos, v.exp_sos);
      chk($sformatf("v%0d hold_len", idx), Sym_Len, v.exp_len);
    end
    if (v.chk_lat) begin
      lat = cap_cyc - fall_cyc;
      chk($sformatf("v%0d latency_in_window", idx), (lat >= 1500 && lat <= 1510), 1);
    end
    chk($sformatf("v%0d busy_low", idx), Busy, 1'b0);
  endtask

  vec_t vecs[6];
  vec_t dot_vec;
  int   pre[4];

  initial begin
    vecs[0] = '{9, 100, 300, 50, 32'h38, -1, 1, 5'd9, 16'h0038, 1'b0, SosExp, 1'b0};
    vecs[1] = '{1, 100, 250, 50, 32'h1, -1, 1, 5'd1, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1, 100, 300, 50, 32'h0, 0, 0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3, 100, 300, 50, 32'h0, 1, 1, 5'd2, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1, 100, 700, 50, 32'h1, -1, 1, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{17, 30, 300, 20, 32'h0, -1, 1, 5'd16, 16'h0000, 1'b1, 1'b0, 1'b0};
    dot_vec = '{1, 100, 300, 50, 32'h0, -1, 1, 5'd1, 16'h0000, 1'b0, 1'b0, 1'b0};
    pre     = '{100, 100, 100, 300};

    repeat (4) @(negedge CLK);
    RST = 1'b0;
    chk("rst valid", Sym_Valid, 1'b0);
    chk("rst bits", Sym_Bits, 16'h0);
    chk("rst len", Sym_Len, 5'd0);
    chk("rst err", Sym_Err, 1'b0);
    chk("rst sos", SOS_Det, 1'b0);
    chk("rst busy", Busy, 1'b0);
    wait_ms(5);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

    // Abort an SOS frame halfway through its 5th mark.
    nvalid = 0;
    nsos   = 0;
    for (int i = 0; i < 4; i++) begin
      Pin_In = 1'b1;
      wait_ms(pre[i]);
      Pin_In = 1'b0;
      wait_ms(50);
    end
    Pin_In = 1'b1;
    wait_ms(150);
    chk("mid busy", Busy, 1'b1);
    RST    = 1'b1;
    Pin_In = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort bits", Sym_Bits, 16'h0);
    chk("abort len", Sym_Len, 5'd0);
    chk("abort err", Sym_Err, 1'b0);
    chk("abort busy", Busy, 1'b0);
    chk("abort valid", Sym_Valid, 1'b0);
    wait_ms(300);
    chk("abort no strobe", nvalid, 0);
    chk("abort no sos", nsos, 0);
    run_frame(dot_vec, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
